stack_multi_sequencer: RTL and testbench
========================================

# stack_multi_sequencer

Sequences multi-register push/pop (STM/LDM-style) transfers between the register file and the data memory port. It is started by the instruction decoder with a 16-bit register mask and a stack-pointer register index. While running, it owns the register file's write, inc/dec and one read port, and drives a request/acknowledge memory interface. It reports completion to the control unit with a one-cycle done pulse.

## Interface
- No parameters; widths come from `t_reg` (32 bits) and `t_reg_index` (4 bits).
- clock  in  1  system clock, all state changes on rising edge
- reset  in  1  asynchronous, active-low; low forces IDLE immediately
- start  in  1  begin transfer; sampled only in IDLE
- pop  in  1  0 = push, 1 = pop; latched with start
- mask  in  16  bit n set = transfer rN; latched with start
- sp_index  in  t_reg_index  stack pointer register; latched with start
- sp_data  in  t_reg  current SP value from a register-file read port addressed by rf_incdec_index
- rf_read_data  in  t_reg  register-file read data for rf_read_index
- rf_write, rf_inc, rf_dec  out  1  register-file strobes
- rf_write_index, rf_incdec_index, rf_read_index  out  t_reg_index
- rf_write_data  out  t_reg
- mem_req, mem_write  out  1  memory request; write = store
- mem_addr, mem_wdata  out  t_reg
- mem_ack  in  1  sampled on the clock edge; completes the current request
- mem_rdata  in  t_reg  valid when mem_ack is high
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on completion

## Operation
- States: IDLE, PUSH_DEC, PUSH_STORE, POP_LOAD, DONE.
- IDLE + start:
  - Latch pending = mask with bit sp_index cleared (SP is never transferred).
  - Latch pop and sp_index.
  - Empty pending -> DONE. Otherwise push -> PUSH_DEC, pop -> POP_LOAD.
- Register order:
  - Push takes the highest set bit of pending first.
  - Pop takes the lowest set bit of pending first.
  - Full-descending stack.
- PUSH_DEC: rf_dec=1 for one cycle (SP -= 4) -> PUSH_STORE.
- PUSH_STORE:
  - Drive mem_req=1, mem_write=1, mem_addr=sp_data, rf_read_index=current register, mem_wdata=rf_read_data.
  - Hold until mem_ack.
  - On ack, clear the current bit. Go to PUSH_DEC if pending is non-empty, else DONE.
- POP_LOAD:
  - Drive mem_req=1, mem_write=0, mem_addr=sp_data.
  - On ack, in the same cycle: rf_write=1, rf_write_index=current register, rf_write_data=mem_rdata, rf_inc=1 (SP += 4).
  - Clear the bit. Stay in POP_LOAD if pending is non-empty, else DONE.
- DONE: done=1, busy=1 for one cycle -> IDLE.
- rf_incdec_index = latched sp_index whenever busy.
- All strobes are 0 outside the states above. Index and data outputs are don't-care while their strobe is low and are driven 0.
- start is ignored when not in IDLE. mask and pop are not re-sampled mid-transfer.
- Address arithmetic is modulo 2^32; SP wrap-around (0x0 - 4 = 0xFFFFFFFC) is permitted and not flagged.

## Timing
- Reset outputs: all strobes, mem_req, busy and done are 0; all indices and data are 0; state is IDLE; pending is 0.
- Reset mid-transfer aborts immediately and does not roll back SP or registers already updated.
- The memory request stays asserted with stable address and data until ack.
- Zero-wait memory (ack in the first request cycle):
  - Push of N registers: 2N cycles from the start edge to DONE; done is high in cycle 2N+1.
  - Pop of N registers: N cycles; done is high in cycle N+1.
  - Empty mask: done is high in the cycle after start.
- Each wait cycle without ack adds one cycle per register.
- busy rises on the edge that samples start. The next start is accepted on the edge after DONE.

## Structure
- State enum `t_smseq_state` and the register-count constant (16) go in `registers.vh`, alongside `t_reg` and `t_reg_index`.
- One sub-module, `reg_mask_encoder`: combinational 16-bit priority encoder with a direction input (highest or lowest bit). Outputs are a t_reg_index and an `any` flag.

## Test plan
- Push: SP (r15) = 0x100, r1 = 0x11, r2 = 0x22, mask = 0x0006, ack every cycle.
  - mem[0xFC] = 0x22 is written, then mem[0xF8] = 0x11.
  - SP ends at 0xF8; done pulses in cycle 5.
- Pop from the push result, mask = 0x0006.
  - r1 = 0x11, then r2 = 0x22; SP ends at 0x100; done pulses in cycle 3.
- Mask = 0x8001 with sp_index = 15.
  - Only r0 is transferred; SP changes by exactly 4.
  - Mask = 0x0000 gives done in the cycle after start, with no mem_req.
- Push of 1 register with ack delayed 3 cycles.
  - mem_req, mem_addr and mem_wdata stay stable for 4 cycles; rf_dec is asserted exactly once.
- Wrap: SP = 0x0, push r3.
  - Store goes to 0xFFFFFFFC; SP ends at 0xFFFFFFFC.
- reset low during the second PUSH_STORE of a 3-register push.
  - busy, mem_req and all strobes go 0 immediately; the FSM returns to IDLE.
  - A start after release runs a fresh transfer normally.

Source files
------------

// File: rtl/stack_multi_sequencer_pkg.sv
// Shared types and constants for the multi-register push/pop sequencer.
package stack_multi_sequencer_pkg;

    localparam int NUM_REGS = 16;

    typedef logic [31:0] t_reg;
    typedef logic [3:0]  t_reg_index;

    // Sequencer FSM encoding
    typedef logic [2:0] t_smseq_state;
    localparam t_smseq_state S_IDLE       = 3'd0;
    localparam t_smseq_state S_PUSH_DEC   = 3'd1;
    localparam t_smseq_state S_PUSH_STORE = 3'd2;
    localparam t_smseq_state S_POP_LOAD   = 3'd3;
    localparam t_smseq_state S_DONE       = 3'd4;

    // One-hot mask selecting a single register
    function automatic logic [NUM_REGS-1:0] reg_bit(input t_reg_index idx);
        return NUM_REGS'(1) << idx;
    endfunction

endpackage

// File: rtl/stack_multi_sequencer_reg_mask_encoder.sv
// Priority encoder over a register mask; picks the highest or lowest set bit.
module reg_mask_encoder
    import stack_multi_sequencer_pkg::*;
(
    input  logic [NUM_REGS-1:0] mask,
    input  logic                highest,
    output t_reg_index          index,
    output logic                any
);

    // Scan order makes the last match win: ascending for highest, descending for lowest
    always_comb begin
        index = '0;
        any   = |mask;
        if (highest) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (mask[i]) index = t_reg_index'(i);
        end else begin
            for (int i = NUM_REGS - 1; i >= 0; i--)
                if (mask[i]) index = t_reg_index'(i);
        end
    end

endmodule

// File: rtl/stack_multi_sequencer.sv
// STM/LDM-style sequencer: walks a register mask and moves registers
// between the register file and memory through a full-descending stack.
module stack_multi_sequencer
    import stack_multi_sequencer_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                pop,
    input  logic [NUM_REGS-1:0] mask,
    input  t_reg_index          sp_index,
    input  t_reg                sp_data,
    input  t_reg                rf_read_data,
    output logic                rf_write,
    output logic                rf_inc,
    output logic                rf_dec,
    output t_reg_index          rf_write_index,
    output t_reg_index          rf_incdec_index,
    output t_reg_index          rf_read_index,
    output t_reg                rf_write_data,
    output logic                mem_req,
    output logic                mem_write,
    output t_reg                mem_addr,
    output t_reg                mem_wdata,
    input  logic                mem_ack,
    input  t_reg                mem_rdata,
    output logic                busy,
    output logic                done
);

    t_smseq_state        state;
    logic [NUM_REGS-1:0] pending;
    logic                pop_q;
    t_reg_index          sp_idx_q;

    t_reg_index          cur_idx;
    logic                cur_any;
    logic [NUM_REGS-1:0] pending_next;
    logic [NUM_REGS-1:0] start_pending;

    // Push goes high-to-low, pop goes low-to-high, so stack layout matches
    reg_mask_encoder u_enc (
        .mask    (pending),
        .highest (~pop_q),
        .index   (cur_idx),
        .any     (cur_any)
    );

    // The SP register itself is never part of the transfer
    assign start_pending = mask & ~reg_bit(sp_index);
    assign pending_next  = pending & ~reg_bit(cur_idx);

    // FSM and latched transfer context
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            pending  <= '0;
            pop_q    <= 1'b0;
            sp_idx_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    pending  <= start_pending;
                    pop_q    <= pop;
                    sp_idx_q <= sp_index;
                    if (start_pending == '0) state <= S_DONE;
                    else if (pop)            state <= S_POP_LOAD;
                    else                     state <= S_PUSH_DEC;
                end
                S_PUSH_DEC: state <= S_PUSH_STORE;
                S_PUSH_STORE: if (mem_ack) begin
                    pending <= pending_next;
                    state   <= (|pending_next) ? S_PUSH_DEC : S_DONE;
                end
                S_POP_LOAD: if (mem_ack) begin
                    pending <= pending_next;
                    state   <= (|pending_next) ? S_POP_LOAD : S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes and datapath outputs, all zero unless the state drives them
    always_comb begin
        rf_write        = 1'b0;
        rf_inc          = 1'b0;
        rf_dec          = 1'b0;
        rf_write_index  = '0;
        rf_read_index   = '0;
        rf_write_data   = '0;
        mem_req         = 1'b0;
        mem_write       = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        done            = 1'b0;
        busy            = (state != S_IDLE);
        rf_incdec_index = busy ? sp_idx_q : '0;
        case (state)
            S_PUSH_DEC: rf_dec = 1'b1;
            S_PUSH_STORE: begin
                mem_req       = cur_any;
                mem_write     = cur_any;
                mem_addr      = sp_data;
                rf_read_index = cur_idx;
                mem_wdata     = rf_read_data;
            end
            S_POP_LOAD: begin
                mem_req  = cur_any;
                mem_addr = sp_data;
                if (mem_ack) begin
                    rf_write       = 1'b1;
                    rf_write_index = cur_idx;
                    rf_write_data  = mem_rdata;
                    rf_inc         = 1'b1;
                end
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stack_multi_sequencer.sv
// Directed bench for stack_multi_sequencer with a register-file and memory model.
module tb_stack_multi_sequencer;

    logic        clock, reset, start, pop;
    logic [15:0] mask;
    logic [3:0]  sp_index;
    logic [31:0] sp_data, rf_read_data;
    logic        rf_write, rf_inc, rf_dec;
    logic [3:0]  rf_write_index, rf_incdec_index, rf_read_index;
    logic [31:0] rf_write_data;
    logic        mem_req, mem_write, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy, done;

    stack_multi_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .pop(pop), .mask(mask),
        .sp_index(sp_index), .sp_data(sp_data), .rf_read_data(rf_read_data),
        .rf_write(rf_write), .rf_inc(rf_inc), .rf_dec(rf_dec),
        .rf_write_index(rf_write_index), .rf_incdec_index(rf_incdec_index),
        .rf_read_index(rf_read_index), .rf_write_data(rf_write_data),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Environment: register file, word memory indexed by addr[7:2], ack delay
    logic [31:0] regs [0:15];
    logic [31:0] mem  [0:63];
    logic        tb_we;
    logic [3:0]  tb_widx;
    logic [31:0] tb_wdata;
    int          ack_delay;
    int          wait_cnt;
    int          dec_cnt;
    int          req_cycles;
    logic [31:0] last_waddr;

    assign sp_data      = regs[rf_incdec_index];
    assign rf_read_data = regs[rf_read_index];
    assign mem_rdata    = mem[mem_addr[7:2]];
    assign mem_ack      = mem_req && (wait_cnt == ack_delay);

    // Apply DUT strobes to the models and keep event counters
    always @(posedge clock) begin
        if (tb_we) regs[tb_widx] <= tb_wdata;
        else begin
            if (rf_write) regs[rf_write_index] <= rf_write_data;
            if (rf_inc)   regs[rf_incdec_index] <= regs[rf_incdec_index] + 32'd4;
            if (rf_dec)   regs[rf_incdec_index] <= regs[rf_incdec_index] - 32'd4;
        end
        if (mem_req && mem_write && mem_ack) begin
            mem[mem_addr[7:2]] <= mem_wdata;
            last_waddr         <= mem_addr;
        end
        wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
        if (rf_dec)  dec_cnt    <= dec_cnt + 1;
        if (mem_req) req_cycles <= req_cycles + 1;
    end

    int   n_assert = 0;
    int   n_fail   = 0;
    logic busy_first;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_reg(input logic [3:0] idx, input logic [31:0] v);
        @(negedge clock);
        tb_we = 1'b1; tb_widx = idx; tb_wdata = v;
        @(negedge clock);
        tb_we = 1'b0;
    endtask

    task automatic launch(input logic p, input logic [15:0] m, input logic [3:0] spi);
        @(negedge clock);
        start = 1'b1; pop = p; mask = m; sp_index = spi;
        @(posedge clock);
        #1 start = 1'b0; pop = ~p; mask = 16'hFFFF; sp_index = 4'd0;
    endtask

    // dc = cycle (1 = first after the start edge) in which done is seen; -1 on timeout
    task automatic run(input logic p, input logic [15:0] m, input logic [3:0] spi, output int dc);
        launch(p, m, spi);
        dc = -1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clock);
            if (k == 1) busy_first = busy;
            if (done) begin dc = k; break; end
        end
        @(negedge clock);
    endtask

    int dc, d0, r0;

    initial begin
        reset = 1'b0; start = 1'b0; pop = 1'b0; mask = '0; sp_index = '0;
        tb_we = 1'b0; tb_widx = '0; tb_wdata = '0;
        ack_delay = 0; wait_cnt = 0; dec_cnt = 0; req_cycles = 0; last_waddr = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        for (int i = 0; i < 16; i++) regs[i] = '0;
        set_reg(4'd15, 32'h100);
        set_reg(4'd0, 32'hA0);
        set_reg(4'd1, 32'h11);
        set_reg(4'd2, 32'h22);
        set_reg(4'd3, 32'h33);
        set_reg(4'd4, 32'h44);
        chk("reset_ctrl", {25'd0, busy, done, mem_req, mem_write, rf_write, rf_inc, rf_dec}, 32'd0);
        chk("reset_idx", {20'd0, rf_write_index, rf_incdec_index, rf_read_index}, 32'd0);
        chk("reset_addr", mem_addr, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Push r1,r2 from SP 0x100
        d0 = dec_cnt;
        run(1'b0, 16'h0006, 4'd15, dc);
        chk("push_busy_rise", {31'd0, busy_first}, 32'd1);
        chk("push_done_cyc", dc, 32'd5);
        chk("push_mem_fc", mem[63], 32'h22);
        chk("push_mem_f8", mem[62], 32'h11);
        chk("push_sp", regs[15], 32'hF8);
        chk("push_dec_cnt", dec_cnt - d0, 32'd2);
        chk("push_idle", {31'd0, busy}, 32'd0);

        // Pop back into cleared r1,r2
        set_reg(4'd1, 32'h0);
        set_reg(4'd2, 32'h0);
        run(1'b1, 16'h0006, 4'd15, dc);
        chk("pop_done_cyc", dc, 32'd3);
        chk("pop_r1", regs[1], 32'h11);
        chk("pop_r2", regs[2], 32'h22);
        chk("pop_sp", regs[15], 32'h100);

        // SP bit in mask is dropped
        d0 = dec_cnt;
        run(1'b0, 16'h8001, 4'd15, dc);
        chk("spmask_done_cyc", dc, 32'd3);
        chk("spmask_sp", regs[15], 32'hFC);
        chk("spmask_mem", mem[63], 32'hA0);
        chk("spmask_addr", last_waddr, 32'hFC);
        chk("spmask_dec_cnt", dec_cnt - d0, 32'd1);

        // Empty mask
        r0 = req_cycles;
        run(1'b0, 16'h0000, 4'd15, dc);
        chk("empty_done_cyc", dc, 32'd1);
        chk("empty_no_req", req_cycles - r0, 32'd0);
        chk("empty_sp", regs[15], 32'hFC);

        // Push r2 with ack delayed 3 cycles
        ack_delay = 3;
        d0 = dec_cnt;
        launch(1'b0, 16'h0004, 4'd15);
        @(negedge clock);
        chk("wait_dec", {30'd0, rf_dec, mem_req}, 32'd2);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("wait_req", {31'd0, mem_req}, 32'd1);
            chk("wait_addr", mem_addr, 32'hF8);
            chk("wait_wdata", mem_wdata, 32'h22);
        end
        @(negedge clock);
        chk("wait_done", {31'd0, done}, 32'd1);
        chk("wait_dec_cnt", dec_cnt - d0, 32'd1);
        chk("wait_mem", mem[62], 32'h22);
        ack_delay = 0;
        @(negedge clock);

        // SP wrap-around
        set_reg(4'd15, 32'h0);
        run(1'b0, 16'h0008, 4'd15, dc);
        chk("wrap_done_cyc", dc, 32'd3);
        chk("wrap_sp", regs[15], 32'hFFFFFFFC);
        chk("wrap_addr", last_waddr, 32'hFFFFFFFC);
        chk("wrap_mem", mem[63], 32'h33);

        // Reset during the second store of a 3-register push
        set_reg(4'd15, 32'h100);
        launch(1'b0, 16'h000E, 4'd15);
        repeat (4) @(negedge clock);
        chk("abort_in_store", {31'd0, mem_req}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_ctrl", {25'd0, busy, done, mem_req, mem_write, rf_write, rf_inc, rf_dec}, 32'd0);
        chk("abort_sp_kept", regs[15], 32'hF8);
        @(negedge clock);
        chk("abort_idle", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        run(1'b0, 16'h0010, 4'd15, dc);
        chk("fresh_done_cyc", dc, 32'd3);
        chk("fresh_sp", regs[15], 32'hF4);
        chk("fresh_mem", mem[61], 32'h44);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
